// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and control strobes exchanged
// between the multi-cycle control unit (master) and the datapath/memory (slave).
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       aluop;
  logic [1:0]       data_to_reg_sel;
  logic [1:0]       jump;
  logic             instr_done;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, mem_ready, branch_taken,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
           alu_src_a, alu_src_b, aluop, data_to_reg_sel, jump,
           instr_done, trap, trap_cause, state_o, instret
  );

  modport slave (
    output opcode, mem_ready, branch_taken,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
           alu_src_a, alu_src_b, aluop, data_to_reg_sel, jump,
           instr_done, trap, trap_cause, state_o, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RISC-V control sequencer
// (FETCH -> DECODE -> EXEC -> [MEM] -> [WB]) sharing one memory port and one ALU.
// Memory waits are bounded by MEM_TIMEOUT; illegal opcodes and timeouts trap
// until reset. Optional retired-instruction counter: MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_TRAP   = 4'd5
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  // Last wait count before a timeout: the trap fires when this waiting cycle
  // would bring the count up to MEM_TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;

  // State, wait counter and trap cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and output decode. The wait counter defaults to zero so it is
  // already clear on entry to FETCH or MEM; it only counts while waiting.
  // Everything stays 0 while rst is high, which also aborts a pending retire.
  always_comb begin
    state_d             = state_q;
    wait_d              = '0;
    cause_d             = cause_q;
    bus.mem_req         = 1'b0;
    bus.mem_we          = 1'b0;
    bus.addr_sel        = 1'b0;
    bus.ir_write        = 1'b0;
    bus.pc_write        = 1'b0;
    bus.pc_src          = 1'b0;
    bus.reg_write       = 1'b0;
    bus.alu_src_a       = 2'b00;
    bus.alu_src_b       = 2'b00;
    bus.aluop           = 2'b00;
    bus.data_to_reg_sel = 2'b00;
    bus.jump            = 2'b00;
    bus.instr_done      = 1'b0;
    bus.trap            = 1'b0;
    bus.trap_cause      = 2'b00;
    bus.state_o         = 4'd0;
    if (!rst) begin
      bus.state_o = state_q;
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_DECODE;
          end else if (wait_q == TO_LAST) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          case (bus.opcode)
            OP_IMM, OP_REG, OP_LOAD, OP_STORE, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC, OP_BRANCH: state_d = S_EXEC;
            default: begin
              state_d = S_TRAP;
              cause_d = 2'b01;
            end
          endcase
        end
        S_EXEC: begin
          case (bus.opcode)
            OP_REG: begin
              bus.alu_src_a = 2'b01;
              bus.aluop     = 2'b10;
              state_d       = S_WB;
            end
            OP_IMM: begin
              bus.alu_src_a = 2'b01;
              bus.alu_src_b = 2'b01;
              bus.aluop     = 2'b10;
              state_d       = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              bus.alu_src_a = 2'b01;
              bus.alu_src_b = 2'b01;
              state_d       = S_MEM;
            end
            OP_BRANCH: begin
              bus.alu_src_a  = 2'b01;
              bus.aluop      = 2'b01;
              bus.jump       = 2'b01;
              bus.pc_write   = bus.branch_taken;
              bus.pc_src     = bus.branch_taken;
              bus.instr_done = 1'b1;
              state_d        = S_FETCH;
            end
            OP_JAL, OP_JALR: begin
              bus.alu_src_a  = (bus.opcode == OP_JAL) ? 2'b10 : 2'b01;
              bus.alu_src_b  = 2'b01;
              bus.jump       = (bus.opcode == OP_JAL) ? 2'b01 : 2'b11;
              bus.pc_write   = 1'b1;
              bus.pc_src     = 1'b1;
              bus.reg_write  = 1'b1;
              bus.instr_done = 1'b1;
              state_d        = S_FETCH;
            end
            OP_LUI: state_d = S_WB;
            OP_AUIPC: begin
              bus.alu_src_a = 2'b10;
              bus.alu_src_b = 2'b01;
              bus.jump      = 2'b10;
              state_d       = S_WB;
            end
            default: begin
              // Opcode changed under a decoded instruction: treat as illegal.
              state_d = S_TRAP;
              cause_d = 2'b01;
            end
          endcase
        end
        S_MEM: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          bus.mem_we   = (bus.opcode == OP_STORE);
          if (bus.mem_ready) begin
            if (bus.opcode == OP_STORE) begin
              bus.instr_done = 1'b1;
              state_d        = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_q == TO_LAST) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          case (bus.opcode)
            OP_LUI:  bus.data_to_reg_sel = 2'b10;
            OP_LOAD: bus.data_to_reg_sel = 2'b11;
            default: bus.data_to_reg_sel = 2'b01;
          endcase
          state_d = S_FETCH;
        end
        S_TRAP: begin
          bus.trap       = 1'b1;
          bus.trap_cause = cause_q;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Retired-instruction count; instr_done is already 0 in TRAP and under rst.
  always_comb begin
    instret_d = instret_q + CNT_W'(bus.instr_done);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign bus.instret = rst ? '0 : instret_q;
`else
  assign bus.instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction sequences checked
// cycle by cycle against a phase-table model of the control sequencer.
module tb_multicycle_control;
  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CW)) bus ();
  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] alu_a, alu_b, aluop, dtr, jump;
    logic       done, trap;
    logic [1:0] cause;
    logic [3:0] st;
  } outs_t;

  typedef enum {PH_RST, PH_FWAIT, PH_FACC, PH_DEC, PH_EXEC, PH_MWAIT, PH_MACC, PH_WB, PH_TRAP} phase_e;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned retired  = 0;
  logic [1:0]  cause_m  = 2'b00;
  logic [6:0]  legal_ops [9] = '{7'd19, 7'd51, 7'd3, 7'd35, 7'd111, 7'd103, 7'd55, 7'd23, 7'd99};

  function automatic bit is_legal(logic [6:0] op);
    return op inside {7'd19, 7'd51, 7'd3, 7'd35, 7'd111, 7'd103, 7'd55, 7'd23, 7'd99};
  endfunction

  // Expected outputs for one cycle, from the per-phase rules of the control unit.
  function automatic outs_t model(phase_e ph, logic [6:0] op, logic taken, logic [1:0] cause);
    outs_t o;
    o = '0;
    case (ph)
      PH_FWAIT: o.mem_req = 1'b1;
      PH_FACC: begin o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1; end
      PH_DEC: o.st = 4'd1;
      PH_EXEC: begin
        o.st = 4'd2;
        case (op)
          7'd51: begin o.alu_a = 2'd1; o.aluop = 2'd2; end
          7'd19: begin o.alu_a = 2'd1; o.alu_b = 2'd1; o.aluop = 2'd2; end
          7'd3, 7'd35: begin o.alu_a = 2'd1; o.alu_b = 2'd1; end
          7'd99: begin
            o.alu_a = 2'd1; o.aluop = 2'd1; o.jump = 2'd1;
            o.pc_write = taken; o.pc_src = taken; o.done = 1'b1;
          end
          7'd111: begin
            o.alu_a = 2'd2; o.alu_b = 2'd1; o.jump = 2'd1;
            o.pc_write = 1'b1; o.pc_src = 1'b1; o.reg_write = 1'b1; o.done = 1'b1;
          end
          7'd103: begin
            o.alu_a = 2'd1; o.alu_b = 2'd1; o.jump = 2'd3;
            o.pc_write = 1'b1; o.pc_src = 1'b1; o.reg_write = 1'b1; o.done = 1'b1;
          end
          7'd23: begin o.alu_a = 2'd2; o.alu_b = 2'd1; o.jump = 2'd2; end
          default: ;
        endcase
      end
      PH_MWAIT, PH_MACC: begin
        o.st = 4'd3; o.mem_req = 1'b1; o.addr_sel = 1'b1;
        o.mem_we = (op == 7'd35);
        o.done = (ph == PH_MACC) && (op == 7'd35);
      end
      PH_WB: begin
        o.st = 4'd4; o.reg_write = 1'b1; o.done = 1'b1;
        o.dtr = (op == 7'd3) ? 2'd3 : (op == 7'd55) ? 2'd2 : 2'd1;
      end
      PH_TRAP: begin o.st = 4'd5; o.trap = 1'b1; o.cause = cause; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.mem_req = bus.mem_req;   o.mem_we = bus.mem_we;     o.addr_sel = bus.addr_sel;
    o.ir_write = bus.ir_write; o.pc_write = bus.pc_write; o.pc_src = bus.pc_src;
    o.reg_write = bus.reg_write;
    o.alu_a = bus.alu_src_a;   o.alu_b = bus.alu_src_b;   o.aluop = bus.aluop;
    o.dtr = bus.data_to_reg_sel; o.jump = bus.jump;
    o.done = bus.instr_done;   o.trap = bus.trap;         o.cause = bus.trap_cause;
    o.st = bus.state_o;
    return o;
  endfunction

  function automatic logic [CW-1:0] instret_exp();
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    return CW'(retired);
`else
    return '0;
`endif
  endfunction

  // One clock: inputs already driven; compare at negedge, advance to posedge+1.
  task automatic step(phase_e ph, logic [6:0] op, logic taken, string tag);
    outs_t exp, got;
    logic [CW-1:0] exp_ir;
    exp = model(ph, op, taken, cause_m);
    exp_ir = instret_exp();
    @(negedge clk);
    got = observe();
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed outputs %h, expected %h", tag, got, exp);
    end
    n_checks++;
    assert (bus.instret === exp_ir) else begin
      n_fail++;
      $error("FAIL %s/instret: observed %0d, expected %0d", tag, bus.instret, exp_ir);
    end
    if (exp.done) retired++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int unsigned n);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b1;
    retired = 0;
    cause_m = 2'b00;
    for (int unsigned i = 0; i < n; i++) step(PH_RST, bus.opcode, 1'b0, "reset");
    rst = 1'b0;
  endtask

  task automatic trap_hold(int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.opcode = 7'($urandom);
      bus.mem_ready = 1'($urandom);
      bus.branch_taken = 1'($urandom);
      step(PH_TRAP, bus.opcode, 1'b0, "trap_hold");
    end
  endtask

  // Full instruction: fw fetch waits, mw memory waits; stops when a trap is due.
  task automatic run_instr(logic [6:0] op, int unsigned fw, int unsigned mw, logic taken, string tag);
    bus.opcode = op;
    for (int unsigned i = 0; i < fw && i < TO; i++) begin
      bus.mem_ready = 1'b0; bus.branch_taken = 1'($urandom);
      step(PH_FWAIT, op, 1'b0, {tag, "/fetch_wait"});
    end
    if (fw >= TO) begin cause_m = 2'b10; return; end
    bus.mem_ready = 1'b1;
    step(PH_FACC, op, 1'b0, {tag, "/fetch"});
    bus.mem_ready = 1'($urandom);
    step(PH_DEC, op, 1'b0, {tag, "/decode"});
    if (!is_legal(op)) begin cause_m = 2'b01; return; end
    bus.branch_taken = (op == 7'd99) ? taken : 1'($urandom);
    bus.mem_ready = 1'($urandom);
    step(PH_EXEC, op, bus.branch_taken, {tag, "/exec"});
    if (op == 7'd3 || op == 7'd35) begin
      for (int unsigned i = 0; i < mw && i < TO; i++) begin
        bus.mem_ready = 1'b0;
        step(PH_MWAIT, op, 1'b0, {tag, "/mem_wait"});
      end
      if (mw >= TO) begin cause_m = 2'b10; return; end
      bus.mem_ready = 1'b1;
      step(PH_MACC, op, 1'b0, {tag, "/mem"});
    end
    if (op inside {7'd51, 7'd19, 7'd55, 7'd23, 7'd3}) begin
      bus.mem_ready = 1'($urandom);
      step(PH_WB, op, 1'b0, {tag, "/wb"});
    end
  endtask

  initial begin
    logic [6:0] op;
    rst = 1'b1;
    bus.opcode = 7'd0;
    bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0;
    do_reset(2);

    run_instr(7'd51, 0, 0, 1'b0, "rtype");
    run_instr(7'd3, 0, 3, 1'b0, "load_wait3");
    run_instr(7'd99, 0, 0, 1'b1, "branch_taken");
    run_instr(7'd99, 0, 0, 1'b0, "branch_not_taken");
    run_instr(7'd111, 0, 0, 1'b0, "jal");
    run_instr(7'd103, 0, 0, 1'b0, "jalr");
    run_instr(7'd55, 0, 0, 1'b0, "lui");
    run_instr(7'd23, 0, 0, 1'b0, "auipc");
    run_instr(7'd19, 0, 0, 1'b0, "itype");
    run_instr(7'd35, 1, 2, 1'b0, "store");
    run_instr(7'd51, TO - 1, 0, 1'b0, "fetch_ready_at_limit");

    for (int k = 0; k < 40; k++) begin
      op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'($urandom), "random");
    end

    run_instr(7'h7F, 0, 0, 1'b0, "illegal");
    trap_hold(20);
    do_reset(1);
    run_instr(7'd51, 0, 0, 1'b0, "after_illegal");

    run_instr(7'd51, TO, 0, 1'b0, "fetch_timeout");
    trap_hold(5);
    do_reset(1);

    run_instr(7'd3, 0, TO, 1'b0, "mem_timeout");
    trap_hold(3);
    do_reset(1);
    run_instr(7'd35, 0, TO - 1, 1'b0, "mem_ready_at_limit");

    for (int k = 0; k < 4; k++) begin
      op = 7'($urandom);
      while (is_legal(op)) op = 7'($urandom);
      run_instr(op, 0, 0, 1'b0, "random_illegal");
      trap_hold(2);
      do_reset(1);
    end

    // Store aborted by reset while waiting in MEM.
    bus.opcode = 7'd35;
    bus.mem_ready = 1'b1;
    step(PH_FACC, 7'd35, 1'b0, "abort/fetch");
    step(PH_DEC, 7'd35, 1'b0, "abort/decode");
    step(PH_EXEC, 7'd35, 1'b0, "abort/exec");
    bus.mem_ready = 1'b0;
    step(PH_MWAIT, 7'd35, 1'b0, "abort/mem_wait");
    do_reset(1);
    bus.mem_ready = 1'b0;
    step(PH_FWAIT, 7'd35, 1'b0, "abort/fetch_after");
    bus.mem_ready = 1'b1;
    step(PH_FACC, 7'd35, 1'b0, "abort/refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
